tick_sched: RTL and testbench
=============================

# tick_sched

Multi-channel event scheduler driven by the system's one-cycle ten-hertz strobe. It lets several consumers share the single slow time base, each with its own programmable period. Consumers include the PWM ramp, the VGA cursor blink and the PS/2 receive timeout. Each channel counts base ticks, issues one-cycle pulses periodically or once, and reports busy/done status to the control logic.

## Interface
Parameters:
- NCH, 4, number of channels (1..8)
- PW, 8, period counter width in base ticks

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- tick_in  in  1  one-cycle base strobe from the ten-hertz divider
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  $clog2(NCH) (min 1)  channel written by cfg_we
- cfg_period  in  PW  period in base ticks
- cfg_mode  in  1  0 = periodic, 1 = one-shot
- start  in  NCH  per-channel start/restart request (one-cycle)
- stop  in  NCH  per-channel stop request (one-cycle)
- done_clr  in  NCH  per-channel clear of sticky done flag
- ch_pulse  out  NCH  one-cycle event pulse, registered
- ch_busy  out  NCH  channel in RUN
- ch_done  out  NCH  sticky one-shot completion flag

## Operation
- Per channel: shadow period/mode (written by cfg), active period/mode, PW-bit down-counter, state IDLE/RUN/DONE.
- cfg_we writes shadow period and mode of cfg_ch only. cfg_ch >= NCH: write ignored.
- Shadow values are copied to active on start, and on each periodic reload. A write during RUN never disturbs the current count.
- IDLE or DONE + start:
  - If shadow period = 0: start is ignored and state is unchanged.
  - Otherwise: load active, cnt <= period, go to RUN, and clear ch_done.
- RUN + start (nonzero shadow): restart with the same load action as above. No pulse is issued.
- RUN + stop → IDLE; cnt held; no pulse. stop in IDLE/DONE has no effect.
- start and stop in the same cycle: stop wins.
- RUN + tick_in (no start/stop):
  - cnt > 1: decrement cnt.
  - cnt == 1, periodic: pulse, reload from shadow, stay in RUN. If the shadow is 0 at reload, pulse and go to IDLE.
  - cnt == 1, one-shot: pulse, set ch_done, go to DONE.
- tick_in in the same cycle as start or stop on a channel: the tick is not counted for that channel.
- done_clr clears ch_done. If set and clear occur in the same cycle, set wins. done_clr has no effect on state.
- Channels are fully independent. Multiple channels may pulse in the same cycle; there is no serialization.
- Width rule: period p yields exactly p base ticks between the load and the first pulse, and p ticks between pulses. Maximum period is 2^PW − 1.

## Timing
- Reset (reset = 0, asynchronous): all channels are in IDLE, and all shadow/active periods, modes, counters, ch_pulse, ch_busy and ch_done are 0.
- The outputs are registered.
- ch_busy rises the cycle after start is sampled and falls the cycle after stop is sampled or the final one-shot tick.
- ch_pulse is high for exactly one cycle, the cycle after the terminal tick_in is sampled.
- ch_done rises in the same cycle as the terminal one-shot pulse.
- Reset asserted mid-count aborts immediately; no pulse is issued.
- tick_in is assumed to be at most one cycle wide. A tick held high for k cycles counts k ticks.

## Test plan
- Reset: hold reset = 0 with arbitrary inputs → all outputs 0. Release, then start ch0 with period 0 → ch_busy stays 0.
- Periodic:
  - Stimulus: ch1 period 3, periodic; start; 10 ticks.
  - Response: ch_pulse[1] one cycle after ticks 3, 6 and 9; ch_busy[1] = 1 throughout.
- One-shot:
  - Stimulus: ch2 period 2, one-shot; start; 4 ticks.
  - Response: single pulse after tick 2. ch_done[2] = 1 and ch_busy[2] = 0 thereafter.
  - Then done_clr → ch_done[2] = 0. done_clr coincident with a new completion → ch_done stays 1.
- Reconfigure while running:
  - Stimulus: ch0 period 4 running; write period 2 after tick 1.
  - Response: first pulse still after tick 4, then pulses every 2 ticks.
- Collisions:
  - start + stop in the same cycle → IDLE.
  - start coincident with tick_in → the tick is not counted; first pulse comes p ticks later.
  - Restart at cnt = 1 → no pulse.
- Parallel channels and reset:
  - Stimulus: all NCH channels set to period 1, started together; then reset asserted between ticks.
  - Response: all pulse bits high in the same cycle on each tick. After reset, nothing pulses again until a new cfg/start.

Source files
------------

// File: rtl/tick_sched.sv
// Multi-channel tick scheduler: each channel counts base strobes and issues
// periodic or one-shot single-cycle pulses with busy/done status.
module tick_sched #(
   parameter  int NCH = 4,
   parameter  int PW  = 8,
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           tick_in,
   input  logic           cfg_we,
   input  logic [CW-1:0]  cfg_ch,
   input  logic [PW-1:0]  cfg_period,
   input  logic           cfg_mode,
   input  logic [NCH-1:0] start,
   input  logic [NCH-1:0] stop,
   input  logic [NCH-1:0] done_clr,
   output logic [NCH-1:0] ch_pulse,
   output logic [NCH-1:0] ch_busy,
   output logic [NCH-1:0] ch_done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state_r         [NCH];
   logic [PW-1:0] shadow_period_r [NCH];
   logic          shadow_mode_r   [NCH];
   logic          active_mode_r   [NCH];
   logic [PW-1:0] cnt_r           [NCH];
   logic [NCH-1:0] load_s;

   // Load request per channel: start without stop, and a usable shadow period
   always_comb begin
      load_s = {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
         if (start[i] && !stop[i] && (shadow_period_r[i] != {PW{1'b0}})) begin
            load_s[i] = 1'b1;
         end else begin
            load_s[i] = 1'b0;
         end
      end
   end

   // Per-channel configuration, counter and state machine with registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NCH; i++) begin
            state_r[i]         <= ST_IDLE;
            shadow_period_r[i] <= {PW{1'b0}};
            shadow_mode_r[i]   <= 1'b0;
            active_mode_r[i]   <= 1'b0;
            cnt_r[i]           <= {PW{1'b0}};
         end
         ch_pulse <= {NCH{1'b0}};
         ch_busy  <= {NCH{1'b0}};
         ch_done  <= {NCH{1'b0}};
      end else begin
         for (int i = 0; i < NCH; i++) begin
            ch_pulse[i] <= 1'b0;
            // cfg_ch values at or above NCH never match, so such writes drop
            if (cfg_we && (cfg_ch == CW'(i))) begin
               shadow_period_r[i] <= cfg_period;
               shadow_mode_r[i]   <= cfg_mode;
            end
            // Clear first so a completion later in this block overrides it
            if (done_clr[i]) begin
               ch_done[i] <= 1'b0;
            end
            if (load_s[i]) begin
               cnt_r[i]         <= shadow_period_r[i];
               active_mode_r[i] <= shadow_mode_r[i];
               state_r[i]       <= ST_RUN;
               ch_busy[i]       <= 1'b1;
               ch_done[i]       <= 1'b0;
            end else begin
               case (state_r[i])
                  ST_IDLE, ST_DONE: begin
                     state_r[i] <= state_r[i];
                  end
                  ST_RUN: begin
                     if (stop[i]) begin
                        state_r[i] <= ST_IDLE;
                        ch_busy[i] <= 1'b0;
                     end else if (tick_in && !start[i]) begin
                        if (cnt_r[i] != PW'(1)) begin
                           cnt_r[i] <= cnt_r[i] - PW'(1);
                        end else if (active_mode_r[i]) begin
                           ch_pulse[i] <= 1'b1;
                           ch_done[i]  <= 1'b1;
                           state_r[i]  <= ST_DONE;
                           ch_busy[i]  <= 1'b0;
                        end else begin
                           ch_pulse[i]      <= 1'b1;
                           cnt_r[i]         <= shadow_period_r[i];
                           active_mode_r[i] <= shadow_mode_r[i];
                           if (shadow_period_r[i] == {PW{1'b0}}) begin
                              state_r[i] <= ST_IDLE;
                              ch_busy[i] <= 1'b0;
                           end else begin
                              state_r[i] <= ST_RUN;
                           end
                        end
                     end else begin
                        state_r[i] <= ST_RUN;
                     end
                  end
                  default: begin
                     state_r[i] <= ST_IDLE;
                     ch_busy[i] <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_tick_sched.sv
// Scoreboard bench for tick_sched: stimulus queues expected pulse events,
// a negedge monitor pops and compares them as pulses appear.
module tb_tick_sched;

   localparam int NCH = 4;
   localparam int PW  = 8;
   localparam int CW  = 2;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           tick_in = 1'b0;
   logic           cfg_we = 1'b0;
   logic [CW-1:0]  cfg_ch = 2'd0;
   logic [PW-1:0]  cfg_period = 8'd0;
   logic           cfg_mode = 1'b0;
   logic [NCH-1:0] start = 4'b0;
   logic [NCH-1:0] stop = 4'b0;
   logic [NCH-1:0] done_clr = 4'b0;
   logic [NCH-1:0] ch_pulse;
   logic [NCH-1:0] ch_busy;
   logic [NCH-1:0] ch_done;

   typedef struct {
      int             cyc;
      logic [NCH-1:0] pulse;
      logic [NCH-1:0] busy;
      logic [NCH-1:0] done;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   tick_sched #(.NCH(NCH), .PW(PW)) dut (
      .clk(clk), .reset(reset), .tick_in(tick_in), .cfg_we(cfg_we),
      .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_mode(cfg_mode),
      .start(start), .stop(stop), .done_clr(done_clr),
      .ch_pulse(ch_pulse), .ch_busy(ch_busy), .ch_done(ch_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare each presented pulse against the scoreboard head
   always @(negedge clk) begin
      if (ch_pulse != 4'b0) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse cyc=%0d got %b expected none", cyc, ch_pulse);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc != cyc) begin
               errors++;
               $display("FAIL pulse_time got cyc %0d expected cyc %0d", cyc, e.cyc);
            end
            checks++;
            if (ch_pulse != e.pulse) begin
               errors++;
               $display("FAIL pulse_bits cyc=%0d got %b expected %b", cyc, ch_pulse, e.pulse);
            end
            checks++;
            if ((ch_busy & e.pulse) != (e.busy & e.pulse)) begin
               errors++;
               $display("FAIL pulse_busy cyc=%0d got %b expected %b", cyc, ch_busy & e.pulse, e.busy & e.pulse);
            end
            checks++;
            if ((ch_done & e.pulse) != (e.done & e.pulse)) begin
               errors++;
               $display("FAIL pulse_done cyc=%0d got %b expected %b", cyc, ch_done & e.pulse, e.done & e.pulse);
            end
         end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_pulse cyc=%0d got %b expected %b", cyc, ch_pulse, e.pulse);
      end
   end

   task automatic next();
      @(posedge clk);
      #2;
      tick_in  = 1'b0;
      cfg_we   = 1'b0;
      start    = 4'b0;
      stop     = 4'b0;
      done_clr = 4'b0;
   endtask

   task automatic expect_pulse(input logic [NCH-1:0] p, input logic [NCH-1:0] b,
                               input logic [NCH-1:0] d);
      exp_t e;
      e.cyc = cyc + 1;
      e.pulse = p;
      e.busy = b;
      e.done = d;
      q.push_back(e);
   endtask

   task automatic cfg(input int ch, input int p, input logic m);
      next();
      cfg_we = 1'b1;
      cfg_ch = CW'(ch);
      cfg_period = PW'(p);
      cfg_mode = m;
   endtask

   task automatic check(input string name, input logic [NCH-1:0] got,
                        input logic [NCH-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %b expected %b", name, got, exp);
      end
   endtask

   initial begin
      // Reset held with busy inputs
      tick_in = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = 8'd1;
      start = 4'b1111; done_clr = 4'b1111;
      repeat (3) @(posedge clk);
      #2;
      check("reset_pulse", ch_pulse, 4'b0);
      check("reset_busy", ch_busy, 4'b0);
      check("reset_done", ch_done, 4'b0);
      next();
      reset = 1'b1;
      // Period 0 start ignored
      next(); start = 4'b0001;
      next(); next();
      check("zero_period_busy", ch_busy, 4'b0);

      // Periodic ch1, period 3
      cfg(1, 3, 1'b0);
      next(); start = 4'b0010;
      next();
      check("periodic_busy", ch_busy, 4'b0010);
      for (int t = 1; t <= 10; t++) begin
         next(); tick_in = 1'b1;
         if (t % 3 == 0) expect_pulse(4'b0010, 4'b0010, 4'b0000);
         next();
      end
      check("periodic_busy_end", ch_busy, 4'b0010);
      next(); stop = 4'b0010;
      next(); next();
      check("stop_busy", ch_busy, 4'b0);

      // One-shot ch2, period 2
      cfg(2, 2, 1'b1);
      next(); start = 4'b0100;
      for (int t = 1; t <= 4; t++) begin
         next(); tick_in = 1'b1;
         if (t == 2) expect_pulse(4'b0100, 4'b0000, 4'b0100);
         next();
      end
      check("oneshot_done", ch_done, 4'b0100);
      check("oneshot_busy", ch_busy, 4'b0000);
      next(); done_clr = 4'b0100;
      next();
      check("done_clr", ch_done, 4'b0000);
      next(); start = 4'b0100;
      next(); tick_in = 1'b1;
      next(); tick_in = 1'b1; done_clr = 4'b0100;
      expect_pulse(4'b0100, 4'b0000, 4'b0100);
      next(); next();
      check("done_set_wins", ch_done, 4'b0100);

      // Reconfigure ch0 while running: 4 -> 2
      cfg(0, 4, 1'b0);
      next(); start = 4'b0001;
      for (int t = 1; t <= 8; t++) begin
         next(); tick_in = 1'b1;
         if (t == 4 || t == 6 || t == 8) expect_pulse(4'b0001, 4'b0001, 4'b0000);
         next();
         if (t == 1) cfg(0, 2, 1'b0);
      end
      next(); stop = 4'b0001;
      next();

      // Collisions on ch3
      cfg(3, 2, 1'b0);
      next(); start = 4'b1000; stop = 4'b1000;
      next(); next();
      check("start_stop_busy", ch_busy, 4'b0000);
      next(); start = 4'b1000; tick_in = 1'b1;
      for (int t = 1; t <= 3; t++) begin
         next(); tick_in = 1'b1;
         if (t == 2) expect_pulse(4'b1000, 4'b1000, 4'b0000);
         next();
      end
      next(); start = 4'b1000; tick_in = 1'b1;
      for (int t = 1; t <= 2; t++) begin
         next(); tick_in = 1'b1;
         if (t == 2) expect_pulse(4'b1000, 4'b1000, 4'b0000);
         next();
      end
      check("restart_busy", ch_busy, 4'b1000);
      next(); stop = 4'b1000;
      next();

      // Parallel channels, then reset mid-run
      for (int c = 0; c < NCH; c++) cfg(c, 1, 1'b0);
      next(); start = 4'b1111;
      for (int t = 1; t <= 3; t++) begin
         next(); tick_in = 1'b1;
         expect_pulse(4'b1111, 4'b1111, 4'b0000);
         next();
      end
      next();
      reset = 1'b0;
      next();
      check("midreset_pulse", ch_pulse, 4'b0);
      check("midreset_busy", ch_busy, 4'b0);
      check("midreset_done", ch_done, 4'b0);
      reset = 1'b1;
      for (int t = 1; t <= 3; t++) begin
         next(); tick_in = 1'b1;
         next();
      end
      next(); start = 4'b1111;
      next(); next();
      check("post_reset_busy", ch_busy, 4'b0);

      repeat (5) next();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running expected finished");
      $fatal(1);
   end

endmodule
